serializer: RTL and testbench
=============================

// Module: serializer
// PURPOSE
//  Parallel-to-serial converter feeding the deserializer stage. Latches a
//  DATA_BUS_WIDTH word plus a bit count, then shifts the word out one bit per
//  clock. Default order is MSB first, so a full-width burst is rebuilt
//  bit-exact by the downstream deserializer. Rejects new words while busy.
// PARAMETERS
//  DATA_BUS_WIDTH  16  width of parallel input word
//  MIN_LEN         3   smallest legal burst length; shorter non-zero mod rejected
// PORTS
//  clk_i             in   1                        single clock, rising edge
//  rst_ni            in   1                        async reset, active low
//  data_i            in   DATA_BUS_WIDTH           parallel word
//  data_mod_i        in   $clog2(DATA_BUS_WIDTH)   bit count; 0 = full width
//  data_val_i        in   1                        word valid strobe
//  ser_data_o        out  1                        serial bit
//  ser_data_val_o    out  1                        serial bit valid
//  busy_o            out  1                        burst in progress; input ignored
// BEHAVIOUR
//  - One clock clk_i; reset is asynchronous and active-low (rst_ni).
//  - Reset (rst_ni=0): state IDLE_S, counter 0, shift reg 0,
//    ser_data_o=0, ser_data_val_o=0, busy_o=0, all async on reset assertion.
//  - Burst length N = (data_mod_i==0) ? DATA_BUS_WIDTH : data_mod_i.
//  - Accept: data_val_i=1 & busy_o=0 & N>=MIN_LEN at rising edge. Latch
//    data_i into shift reg and N into counter. Go to SEND_S.
//  - Reject: data_val_i=1 with 0<data_mod_i<MIN_LEN. No state change, no
//    output, busy_o stays 0. Same for any data_val_i while busy_o=1.
//  - FSM: IDLE_S -> SEND_S on accept. SEND_S -> IDLE_S after the edge that
//    emits bit N. No other states; illegal encodings -> IDLE_S.
//  - Latency: first bit valid the cycle after the accept edge (registered out).
//  - SEND_S, cycle k=0..N-1: ser_data_val_o=1.
//    ser_data_o = data_i[DATA_BUS_WIDTH-1-k], i.e. top N bits sent MSB first;
//    low DATA_BUS_WIDTH-N bits are never sent.
//  - busy_o=1 in every cycle with ser_data_val_o=1, including the last bit.
//    So the earliest next accept is the edge ending the last bit, giving the
//    next burst's first bit with zero gap (back-to-back bursts contiguous).
//  - IDLE_S: ser_data_val_o=0, ser_data_o=0.
//  - Counter width $clog2(DATA_BUS_WIDTH)+1, decrements by 1 per bit, never
//    wraps; reaching 1 on a bit cycle ends the burst.
//  - Reset mid-burst: burst dropped immediately, no partial resume after
//    release. First edge after release behaves as IDLE_S.
//  - All outputs registered; no combinational path from inputs to outputs.
// CONFIGURATION
//  SERIALIZER_LSB_FIRST_EN
//   undefined (default): MSB first, as above. Matches the deserializer.
//   defined: bit k = data_i[k], k=0..N-1 (low N bits sent, LSB first).
//   Length, latency, handshake and busy timing unchanged.
// TESTING
//  1 reset: hold rst_ni=0 with data_val_i=1 -> all outputs 0. Release ->
//    first accept seen on next edge.
//  2 data_i=16'hA5C3, mod=0 -> 16 valid cycles, bits 1010010111000011 from
//    the cycle after accept. busy_o high same 16 cycles.
//  3 data_i=16'hF000, mod=4 -> 4 valid cycles of 1. mod=2 -> rejected, no
//    valid or busy. mod=3 -> 3 bits 1,1,1.
//  4 new data_val_i during burst -> ignored. Strobe on last-bit cycle ->
//    accepted, second burst starts with no idle cycle.
//  5 rst_ni pulsed low at bit 7 of a 16-bit burst -> outputs 0 at once, no
//    further valid bits until a new accept.
//  6 chain with deserializer (16b), send random words mod=0 -> deser output
//    equals sent word each burst. With SERIALIZER_LSB_FIRST_EN, 16'h0001
//    mod=3 -> bits 1,0,0.

Source files
------------

// File: rtl/serializer_if.sv
// Parallel-word / serial-bit handshake bundle between a word source and the serializer.
interface serializer_if #(
    parameter int DATA_BUS_WIDTH = 16
);
    logic [DATA_BUS_WIDTH-1:0]         data_i;
    logic [$clog2(DATA_BUS_WIDTH)-1:0] data_mod_i;
    logic                              data_val_i;
    logic                              ser_data_o;
    logic                              ser_data_val_o;
    logic                              busy_o;

    modport master (
        output data_i, data_mod_i, data_val_i,
        input  ser_data_o, ser_data_val_o, busy_o
    );

    modport slave (
        input  data_i, data_mod_i, data_val_i,
        output ser_data_o, ser_data_val_o, busy_o
    );
endinterface

// File: rtl/serializer.sv
// Parallel-to-serial converter: latches a word and bit count, shifts it out one bit per clock.
// Bit order is MSB first unless SERIALIZER_LSB_FIRST_EN is defined (then LSB first).
module serializer #(
    parameter int DATA_BUS_WIDTH = 16,
    parameter int MIN_LEN        = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    serializer_if.slave   bus
);
    localparam int MW = $clog2(DATA_BUS_WIDTH);
    localparam int CW = MW + 1;

    typedef enum logic [1:0] {
        IDLE_S = 2'b01,
        SEND_S = 2'b10
    } state_e;

    state_e                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [DATA_BUS_WIDTH-1:0] shift_q, shift_d;
    logic                      ser_q, ser_d;
    logic                      val_q, val_d;
    logic                      busy_q, busy_d;

    logic [CW-1:0]             len;
    logic                      accept_ok;
    logic                      load;

    assign len       = (bus.data_mod_i == '0) ? CW'(DATA_BUS_WIDTH) : {1'b0, bus.data_mod_i};
    assign accept_ok = bus.data_val_i && (len >= CW'(MIN_LEN));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE_S;
            cnt_q   <= '0;
            shift_q <= '0;
            ser_q   <= 1'b0;
            val_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            ser_q   <= ser_d;
            val_q   <= val_d;
            busy_q  <= busy_d;
        end
    end

    // The output registers hold the bit currently on the wire; shift_q holds the bits still to go.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        ser_d   = 1'b0;
        val_d   = 1'b0;
        busy_d  = 1'b0;
        load    = 1'b0;

        case (state_q)
            IDLE_S: begin
                if (accept_ok) load = 1'b1;
            end
            SEND_S: begin
                if (cnt_q > CW'(1)) begin
                    cnt_d  = cnt_q - CW'(1);
                    val_d  = 1'b1;
                    busy_d = 1'b1;
`ifdef SERIALIZER_LSB_FIRST_EN
                    ser_d   = shift_q[0];
                    shift_d = shift_q >> 1;
`else
                    ser_d   = shift_q[DATA_BUS_WIDTH-1];
                    shift_d = shift_q << 1;
`endif
                end else if (accept_ok) begin
                    // Edge ending the last bit may take the next word, so bursts abut.
                    load = 1'b1;
                end else begin
                    state_d = IDLE_S;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            default: begin
                state_d = IDLE_S;
                cnt_d   = '0;
                shift_d = '0;
            end
        endcase

        if (load) begin
            state_d = SEND_S;
            cnt_d   = len;
            val_d   = 1'b1;
            busy_d  = 1'b1;
`ifdef SERIALIZER_LSB_FIRST_EN
            ser_d   = bus.data_i[0];
            shift_d = bus.data_i >> 1;
`else
            ser_d   = bus.data_i[DATA_BUS_WIDTH-1];
            shift_d = bus.data_i << 1;
`endif
        end
    end

    assign bus.ser_data_o     = ser_q;
    assign bus.ser_data_val_o = val_q;
    assign bus.busy_o         = busy_q;
endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: vector table, hand-written corner sequences, random bursts vs queue model.
module tb_serializer;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serializer_if #(.DATA_BUS_WIDTH(W)) bus ();

    serializer #(.DATA_BUS_WIDTH(W), .MIN_LEN(3)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [15:0] data;
        logic [3:0]  mod;
        int          exp_n;
        logic [15:0] exp_seq;   // first sent bit at [15], left-aligned
    } vec_t;

    int tests = 0;
    int fails = 0;
    bit got_q[$];
    bit exp_q[$];
    int busy_bad;
    logic idle_busy;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: the bits a burst should put on the wire, in order.
    task automatic model_push(input logic [15:0] d, input logic [3:0] mod);
        int n;
        n = (mod == 0) ? W : int'(mod);
        if (n < 3) return;
        for (int k = 0; k < n; k++) begin
`ifdef SERIALIZER_LSB_FIRST_EN
            exp_q.push_back(d[k]);
`else
            exp_q.push_back(d[W-1-k]);
`endif
        end
    endtask

    task automatic drive(input logic [15:0] d, input logic [3:0] mod);
        bus.data_i     = d;
        bus.data_mod_i = mod;
        bus.data_val_i = 1'b1;
        @(posedge clk);
        #1 bus.data_val_i = 1'b0;
    endtask

    // Gather contiguous valid bits; optionally strobe another word while bit inj_k is on the wire.
    task automatic collect(input int inj_k, input logic [15:0] id, input logic [3:0] imod);
        bit done;
        done = 1'b0;
        got_q.delete();
        busy_bad = 0;
        idle_busy = 1'b0;
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            if (!bus.ser_data_val_o) begin
                idle_busy = bus.busy_o;
                done = 1'b1;
                break;
            end
            got_q.push_back(bus.ser_data_o);
            if (bus.busy_o !== 1'b1) busy_bad++;
            if (c == inj_k) begin
                bus.data_i     = id;
                bus.data_mod_i = imod;
                bus.data_val_i = 1'b1;
            end
            if (c == inj_k + 1) bus.data_val_i = 1'b0;
        end
        bus.data_val_i = 1'b0;
        if (!done) check("collect_timeout", 32'd1, 32'd0);
    endtask

    task automatic compare_q(input string name);
        int mism;
        mism = 0;
        check({name, "_len"}, got_q.size(), exp_q.size());
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
            if (got_q[k] != exp_q[k]) mism++;
        check({name, "_bits"}, mism, 0);
        check({name, "_busy"}, busy_bad, 0);
        check({name, "_idle_busy"}, {31'd0, idle_busy}, 0);
    endtask

    initial begin
        vec_t vecs[$];
        logic [15:0] seq;
        logic [15:0] rd;
        logic [3:0]  rm;
        int vcnt;

`ifdef SERIALIZER_LSB_FIRST_EN
        vecs.push_back('{16'h0001, 4'd3,  3, 16'h8000});
        vecs.push_back('{16'hA5C3, 4'd0, 16, 16'hC3A5});
        vecs.push_back('{16'hF000, 4'd4,  4, 16'h0000});
        vecs.push_back('{16'hF000, 4'd2,  0, 16'h0000});
        vecs.push_back('{16'h000F, 4'd5,  5, 16'hF000});
        vecs.push_back('{16'h1234, 4'd1,  0, 16'h0000});
`else
        vecs.push_back('{16'hA5C3, 4'd0, 16, 16'hA5C3});
        vecs.push_back('{16'hF000, 4'd4,  4, 16'hF000});
        vecs.push_back('{16'hF000, 4'd2,  0, 16'h0000});
        vecs.push_back('{16'hF000, 4'd3,  3, 16'hE000});
        vecs.push_back('{16'h1234, 4'd1,  0, 16'h0000});
        vecs.push_back('{16'h8001, 4'd3,  3, 16'h8000});
        vecs.push_back('{16'hFFFF, 4'd15, 15, 16'hFFFE});
`endif

        // Reset held with a pending strobe: outputs stay low, accept on first edge after release.
        bus.data_i     = 16'hA5C3;
        bus.data_mod_i = 4'd0;
        bus.data_val_i = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {29'd0, bus.ser_data_o, bus.ser_data_val_o, bus.busy_o}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 bus.data_val_i = 1'b0;
        exp_q.delete();
        model_push(16'hA5C3, 4'd0);
        collect(-1, 16'h0, 4'd0);
        compare_q("first_after_reset");

        foreach (vecs[i]) begin
            drive(vecs[i].data, vecs[i].mod);
            collect(-1, 16'h0, 4'd0);
            seq = '0;
            for (int k = 0; k < got_q.size() && k < W; k++) seq[W-1-k] = got_q[k];
            check($sformatf("vec%0d_len", i), got_q.size(), vecs[i].exp_n);
            check($sformatf("vec%0d_seq", i), {16'd0, seq}, {16'd0, vecs[i].exp_seq});
            check($sformatf("vec%0d_busy", i), busy_bad, 0);
            check($sformatf("vec%0d_idle_busy", i), {31'd0, idle_busy}, 0);
        end

        // Strobe mid-burst is ignored.
        exp_q.delete();
        model_push(16'hA5C3, 4'd0);
        drive(16'hA5C3, 4'd0);
        collect(4, 16'h0000, 4'd3);
        compare_q("busy_ignore");

        // Strobe on the last bit is accepted with no idle gap.
        exp_q.delete();
        model_push(16'hF000, 4'd4);
        model_push(16'h8001, 4'd3);
        drive(16'hF000, 4'd4);
        collect(3, 16'h8001, 4'd3);
        compare_q("back_to_back");

        // Reset asserted while bit 7 of a 16-bit burst is on the wire.
        drive(16'hA5C3, 4'd0);
        for (int k = 0; k < 8; k++) @(negedge clk);
        check("pre_reset_valid", {31'd0, bus.ser_data_val_o}, 1);
        #2 rst_n = 1'b0;
        #1 check("midburst_reset_async", {29'd0, bus.ser_data_o, bus.ser_data_val_o, bus.busy_o}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        vcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.ser_data_val_o || bus.busy_o) vcnt++;
        end
        check("no_resume_after_reset", vcnt, 0);
        exp_q.delete();
        model_push(16'h1234, 4'd0);
        drive(16'h1234, 4'd0);
        collect(-1, 16'h0, 4'd0);
        compare_q("recover_after_reset");

        for (int r = 0; r < 40; r++) begin
            rd = 16'($urandom);
            rm = 4'($urandom_range(0, 15));
            exp_q.delete();
            model_push(rd, rm);
            drive(rd, rm);
            collect(-1, 16'h0, 4'd0);
            compare_q($sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
